// File: rtl/fifo_2bit_buffer.sv
// Four-entry FIFO behind the 2-bit valid-qualified mux: captures each valid word,
// returns it one cycle after a pop, and reports occupancy plus sticky error flags.
module fifo_2bit_buffer #(
    parameter int DATA_WIDTH   = 2,
    parameter int ADDR_WIDTH   = 2,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  validIN,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOUT,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AF_C    = ALMOST_FULL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_C    = ALMOST_EMPTY[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vld_q, vld_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_acc, pop_acc;

    // Pop is decided first so a full FIFO can accept a push into the slot being freed.
    assign pop_acc  = pop && (count_q != '0);
    assign push_acc = validIN && ((count_q != DEPTH_C) || pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q];
            vld_d    = 1'b1;
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end
        if (validIN && !push_acc) begin
            ovf_d = 1'b1;
        end
        if (pop && !pop_acc) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset; pointers guard stale entries.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    assign dataOut      = dout_q;
    assign validOUT     = vld_q;
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_2bit_buffer.sv
// Bench for fifo_2bit_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_fifo_2bit_buffer;

    logic       clk;
    logic       reset;
    logic [1:0] dataIn;
    logic       validIN;
    logic       pop;
    logic [1:0] dataOut;
    logic       validOUT;
    logic [2:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int m_q[$];
    int m_dout;
    bit m_vld, m_ovf, m_udf;

    fifo_2bit_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn      (dataIn),
        .validIN     (validIN),
        .pop         (pop),
        .dataOut     (dataOut),
        .validOUT    (validOUT),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        assert (act === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = 0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"},    32'(count),        32'(n));
        chk({tag, ".full"},     32'(full),         32'(n == 4));
        chk({tag, ".empty"},    32'(empty),        32'(n == 0));
        chk({tag, ".afull"},    32'(almost_full),  32'(n >= 3));
        chk({tag, ".aempty"},   32'(almost_empty), 32'(n <= 1));
        chk({tag, ".validOUT"}, 32'(validOUT),     32'(m_vld));
        chk({tag, ".dataOut"},  32'(dataOut),      32'(m_dout));
        chk({tag, ".overflow"}, 32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},32'(underflow),    32'(m_udf));
    endtask

    // One clock with the given request; model follows the FIFO rules directly.
    task automatic step(input string tag, input bit v, input logic [1:0] d, input bit p);
        bit was_full, was_empty, pop_ok, push_ok;
        validIN = v;
        dataIn  = d;
        pop     = p;
        was_full  = (m_q.size() == 4);
        was_empty = (m_q.size() == 0);
        pop_ok  = p && !was_empty;
        push_ok = v && (!was_full || pop_ok);
        @(posedge clk);
        if (pop_ok) begin
            m_dout = m_q.pop_front();
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (p && was_empty) m_udf = 1'b1;
        if (v && !push_ok)  m_ovf = 1'b1;
        if (push_ok) m_q.push_back(int'(d));
        #1;
        check_all(tag);
    endtask

    // Asserts reset mid-cycle and checks it takes effect before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] pat [4];
        pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b00;
        reset   = 1'b1;
        validIN = 1'b1;
        dataIn  = 2'b11;
        pop     = 1'b1;
        model_reset();

        // Reset held while pushes and pops are requested
        repeat (2) @(posedge clk);
        #1;
        check_all("t1_reset");
        chk("t1_dataOut_zero", 32'(dataOut), 32'h0);
        reset = 1'b0;

        // In-order fill and drain
        for (int i = 0; i < 4; i++) step("t2_push", 1'b1, pat[i], 1'b0);
        chk("t2_full", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("t2_pop", 1'b0, 2'b00, 1'b1);
            chk("t2_order", 32'(dataOut), 32'(pat[i]));
        end
        step("t2_idle", 1'b0, 2'b00, 1'b0);
        chk("t2_empty", 32'(empty), 32'h1);

        // Overflow drops the extra word
        for (int i = 0; i < 4; i++) step("t3_fill", 1'b1, pat[i], 1'b0);
        step("t3_ovf", 1'b1, 2'b10, 1'b0);
        chk("t3_ovf_flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) step("t3_pop", 1'b0, 2'b00, 1'b1);
        step("t3_extra_pop", 1'b0, 2'b00, 1'b1);

        // Simultaneous push/pop while full
        async_reset("t4_rst");
        for (int i = 0; i < 4; i++) step("t4_fill", 1'b1, pat[i], 1'b0);
        step("t4_both", 1'b1, 2'b01, 1'b1);
        chk("t4_oldest", 32'(dataOut), 32'h3);
        chk("t4_no_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) step("t4_pop", 1'b0, 2'b00, 1'b1);
        chk("t4_last", 32'(dataOut), 32'h1);

        // Empty edge cases
        async_reset("t5_rst");
        step("t5_pop_empty", 1'b0, 2'b00, 1'b1);
        chk("t5_udf", 32'(underflow), 32'h1);
        step("t5_both_empty", 1'b1, 2'b10, 1'b1);
        chk("t5_count1", 32'(count), 32'h1);
        step("t5_pop", 1'b0, 2'b00, 1'b1);
        chk("t5_data", 32'(dataOut), 32'h2);

        // Pointer wrap then reset mid-burst
        async_reset("t6_rst0");
        step("t6_prime", 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 6; i++) step("t6_pair", 1'b1, 2'(i), 1'b1);
        validIN = 1'b1;
        dataIn  = 2'b10;
        pop     = 1'b0;
        async_reset("t6_mid");
        step("t6_push", 1'b1, 2'b11, 1'b0);
        step("t6_pop", 1'b0, 2'b00, 1'b1);
        chk("t6_data", 32'(dataOut), 32'h3);

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                validIN = 1'(($urandom));
                async_reset("rnd_rst");
            end else begin
                step("rnd", 1'($urandom_range(0, 99) < 55), 2'($urandom),
                     1'($urandom_range(0, 99) < 45));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
